// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES CTR sequencing stage.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // S_NOIV: waiting for an IV, S_RUN: idle and ready, S_CALC: core settling,
  // S_OUT: result presented downstream.
  typedef enum logic [1:0] {
    S_NOIV = 2'd0,
    S_RUN  = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } ctr_state_e;

  // Increment only the low 'width' bits of the counter block. The low field
  // wraps to zero, and no carry propagates into the upper bits.
  function automatic aes_block_t ctr_inc(input aes_block_t blk, input int width);
    aes_block_t mask;
    aes_block_t inc;
    if (width >= AES_BLOCK_W) begin
      mask = {AES_BLOCK_W{1'b1}};
    end else if (width <= 0) begin
      mask = {AES_BLOCK_W{1'b0}};
    end else begin
      mask = (128'd1 << width) - 128'd1;
    end
    inc = blk + 128'd1;
    return (blk & ~mask) | (inc & mask);
  endfunction

endpackage

// File: rtl/aes_ctr_stage.sv
// CTR-mode sequencing stage placed around a combinational AES-128 core.
// The stage holds the counter block and drives it to the core plaintext input.
// It XORs the core ciphertext (the keystream) with each accepted data block.
// The core_pt -> core_ct path is a two-cycle multicycle path. core_pt changes
// only on iv_load or at the end of S_CALC, so it is stable for at least two
// cycles before core_ct is sampled.
module aes_ctr_stage
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iv_load,
  input  logic [AES_BLOCK_W-1:0] iv,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic [AES_BLOCK_W-1:0] core_pt,
  input  logic [AES_BLOCK_W-1:0] core_ct,
  output logic                   busy
);

  ctr_state_e state_q;
  ctr_state_e state_d;
  aes_block_t ctr_q;
  aes_block_t ctr_d;
  aes_block_t data_q;
  aes_block_t data_d;
  aes_block_t out_data_q;
  aes_block_t out_data_d;
  logic       out_valid_q;
  logic       out_valid_d;
  logic       busy_q;
  logic       busy_d;
  logic       in_ready_s;
  logic       accept_s;

  // Ready decode. iv_load blocks every handshake in the cycle it is asserted.
  always_comb begin
    in_ready_s = 1'b0;
    if (iv_load) begin
      in_ready_s = 1'b0;
    end else if (state_q == S_RUN) begin
      in_ready_s = 1'b1;
    end else if ((state_q == S_OUT) && out_ready) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = in_valid && in_ready_s;
  end

  // Next-state logic. iv_load overrides everything and drops any pending block.
  always_comb begin
    state_d = state_q;
    if (iv_load) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_NOIV: state_d = S_NOIV;
        S_RUN: begin
          if (in_valid) begin
            state_d = S_CALC;
          end else begin
            state_d = S_RUN;
          end
        end
        S_CALC: state_d = S_OUT;
        S_OUT: begin
          if (out_ready && in_valid) begin
            state_d = S_CALC;
          end else if (out_ready) begin
            state_d = S_RUN;
          end else begin
            state_d = S_OUT;
          end
        end
        default: state_d = S_NOIV;
      endcase
    end
  end

  // Datapath. Load the counter, capture the input, and form the result
  // while in S_CALC.
  always_comb begin
    ctr_d      = ctr_q;
    data_d     = data_q;
    out_data_d = out_data_q;
    if (iv_load) begin
      ctr_d = iv;
    end else if (state_q == S_CALC) begin
      ctr_d      = ctr_inc(ctr_q, CTR_WIDTH);
      out_data_d = data_q ^ core_ct;
    end else begin
      ctr_d = ctr_q;
    end
    if (accept_s) begin
      data_d = in_data;
    end else begin
      data_d = data_q;
    end
  end

  // Output flag decode from the next state, so that the flags are registered.
  always_comb begin
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      S_NOIV: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      S_RUN: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      S_CALC: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
      end
      S_OUT: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_NOIV;
      ctr_q       <= {AES_BLOCK_W{1'b0}};
      data_q      <= {AES_BLOCK_W{1'b0}};
      out_data_q  <= {AES_BLOCK_W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign core_pt   = ctr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_ctr_stage.sv
// Directed bench for aes_ctr_stage. The AES core stand-in returns the FIPS-197
// ciphertext for the reference counter block (key 000102..0f). For any other
// counter block it returns a fixed scramble, so the keystream is still
// deterministic.
module tb_aes_ctr_stage;

  logic         clk;
  logic         rst;
  logic         iv_load;
  logic [127:0] iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [127:0] core_pt;
  logic [127:0] core_ct;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] IV1     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KS1     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] IV1_P1  = 128'h00112233445566778899aabbccddef00;
  localparam logic [127:0] IV1_P2  = 128'h00112233445566778899aabbccddef01;
  localparam logic [127:0] ONES    = {128{1'b1}};
  // KS1 XOR all-ones, computed byte by byte.
  localparam logic [127:0] KS1_INV = 128'h963b1f279584fbcf2732487f8f4b3aa5;
  localparam logic [127:0] IV3     = 128'ha5a5a5a5a5a5a5a5a5a5a5a5ffffffff;
  localparam logic [127:0] IV3_P1  = 128'ha5a5a5a5a5a5a5a5a5a5a5a500000000;
  localparam logic [127:0] D2      = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] D3      = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] IV5     = 128'hfeedfacecafebeef0011223344556677;

  function automatic logic [127:0] core_model(input logic [127:0] pt);
    if (pt == IV1) begin
      return KS1;
    end else begin
      return {pt[63:0], pt[127:64]} ^ 128'h3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c;
    end
  endfunction

  assign core_ct = core_model(core_pt);

  aes_ctr_stage #(.CTR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .iv_load   (iv_load),
    .iv        (iv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .core_pt   (core_pt),
    .core_ct   (core_ct),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv_load = 1'b1;
    iv      = v;
    tick();
    iv_load = 1'b0;
  endtask

  // Offers one block from S_RUN and leaves the stage in S_OUT.
  task automatic run_block(input logic [127:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [127:0] exp_blk;
    rst = 1'b1; iv_load = 1'b0; iv = 128'h0; in_valid = 1'b0;
    in_data = 128'h0; out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check("rst_out_data", out_data, 128'h0);
    check("rst_core_pt", core_pt, 128'h0);
    check("rst_in_ready", {127'h0, in_ready}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    rst = 1'b0;
    #1;
    check("noiv_in_ready", {127'h0, in_ready}, 128'h0);

    // 1: FIPS-197 reference block, with zero data
    iv_load = 1'b1;
    iv      = IV1;
    tick();
    check("t1_core_pt_iv", core_pt, IV1);
    check("t1_ready_during_load", {127'h0, in_ready}, 128'h0);
    iv_load = 1'b0;
    #1;
    check("t1_ready_run", {127'h0, in_ready}, 128'h1);
    in_valid = 1'b1;
    in_data  = 128'h0;
    tick();
    check("t1_calc_valid", {127'h0, out_valid}, 128'h0);
    check("t1_calc_busy", {127'h0, busy}, 128'h1);
    check("t1_calc_ready", {127'h0, in_ready}, 128'h0);
    in_valid = 1'b0;
    tick();
    check("t1_out_valid", {127'h0, out_valid}, 128'h1);
    check("t1_out_data", out_data, KS1);
    check("t1_core_pt_inc", core_pt, IV1_P1);
    tick();
    check("t1_back_to_run", {127'h0, out_valid}, 128'h0);
    check("t1_idle_busy", {127'h0, busy}, 128'h0);

    // 2: all-ones data, then feed the result back to show CTR symmetry
    load_iv(IV1);
    run_block(ONES);
    check("t2_enc", out_data, KS1_INV);
    tick();
    load_iv(IV1);
    run_block(KS1_INV);
    check("t2_dec", out_data, ONES);
    tick();

    // 3: the low 32-bit field wraps, and the upper bits are untouched
    load_iv(IV3);
    run_block(D3);
    check("t3_core_pt_wrap", core_pt, IV3_P1);
    check("t3_out_data", out_data, core_model(IV3) ^ D3);
    tick();

    // 4: backpressure, then a back-to-back accept
    load_iv(IV1);
    out_ready = 1'b0;
    run_block(D2);
    exp_blk = KS1 ^ D2;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", {127'h0, out_valid}, 128'h1);
      check("t4_hold_data", out_data, exp_blk);
      check("t4_hold_ready", {127'h0, in_ready}, 128'h0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = D3;
    #1;
    check("t4_b2b_ready", {127'h0, in_ready}, 128'h1);
    tick();
    in_valid = 1'b0;
    check("t4_b2b_calc_valid", {127'h0, out_valid}, 128'h0);
    check("t4_b2b_calc_busy", {127'h0, busy}, 128'h1);
    tick();
    check("t4_b2b_valid", {127'h0, out_valid}, 128'h1);
    check("t4_b2b_data", out_data, core_model(IV1_P1) ^ D3);
    check("t4_b2b_core_pt", core_pt, IV1_P2);
    tick();

    // 5: iv_load during S_CALC discards the block
    in_valid = 1'b1;
    in_data  = D2;
    tick();
    in_valid = 1'b0;
    check("t5_in_calc", {127'h0, busy}, 128'h1);
    iv_load = 1'b1;
    iv      = IV5;
    tick();
    check("t5_no_valid", {127'h0, out_valid}, 128'h0);
    check("t5_core_pt", core_pt, IV5);
    check("t5_ready_load_high", {127'h0, in_ready}, 128'h0);
    iv_load = 1'b0;
    #1;
    check("t5_ready_after", {127'h0, in_ready}, 128'h1);
    tick();
    check("t5_still_no_valid", {127'h0, out_valid}, 128'h0);
    check("t5_core_pt_hold", core_pt, IV5);

    // iv_load wins over a simultaneous in_valid in S_RUN
    in_valid = 1'b1;
    in_data  = D3;
    iv_load  = 1'b1;
    iv       = IV1;
    #1;
    check("t5_sim_ready", {127'h0, in_ready}, 128'h0);
    tick();
    iv_load  = 1'b0;
    in_valid = 1'b0;
    check("t5_sim_not_busy", {127'h0, busy}, 128'h0);
    check("t5_sim_core_pt", core_pt, IV1);

    // 6: reset while in S_OUT
    out_ready = 1'b0;
    run_block(D2);
    check("t6_in_out", {127'h0, out_valid}, 128'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out_valid", {127'h0, out_valid}, 128'h0);
    check("t6_out_data", out_data, 128'h0);
    check("t6_core_pt", core_pt, 128'h0);
    check("t6_in_ready", {127'h0, in_ready}, 128'h0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = D3;
    #1;
    check("t6_ignore_ready", {127'h0, in_ready}, 128'h0);
    tick();
    check("t6_ignore_busy", {127'h0, busy}, 128'h0);
    tick();
    check("t6_ignore_valid", {127'h0, out_valid}, 128'h0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
